uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit serializer, the stage directly downstream of the baud tick generator.
- Consumes the one-cycle Tick pulse (one pulse per bit period) and serializes parallel bytes onto the TxD line.
- Format: start bit, LSB-first data, optional parity, stop bit(s).
- A one-entry holding register allows the next byte to be accepted while the current frame is on the line, so back-to-back frames leave no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
Clk  input  1  system clock, all logic on the rising edge.
Rst  input  1  synchronous, active-high reset.
Tick  input  1  bit-period strobe from the baud generator; one cycle wide, period ≥2 Clk.
TxValid  input  1  upstream presents a byte on TxData.
TxData  input  DATA_BITS  byte to send; sampled on accept.
TxReady  output  1  holding register empty; accept = TxValid & TxReady.
TxD  output  1  serial line, registered, idles high.
TxBusy  output  1  high while a frame is on the line (state != IDLE).
TxDone  output  1  one-cycle pulse at the end of the final stop bit.

Behaviour:
- Reset (synchronous, one cycle): state IDLE, TxD=1, hold empty, TxReady=1, TxBusy=0, TxDone=0, counters 0. Reset mid-frame aborts the frame: TxD=1 after the reset edge, held byte discarded, no TxDone.
- Holding register:
  - TxReady = ~hold_full.
  - On accept, TxData is latched and hold_full=1 from the next cycle.
  - hold_full clears on the Tick edge that starts a frame.
  - Accept and frame start cannot coincide, because TxReady=0 whenever hold_full=1.
- State machine: IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles where Tick=1, so every bit lasts exactly one Tick period.
  - IDLE: on Tick with hold_full=1 (as sampled that cycle): load shifter, TxD<=0, go to START. Tick with hold empty is ignored. A byte accepted in the same cycle as a Tick waits for the next Tick.
  - START: on Tick: TxD<=shifter[0], bit_cnt<=0, go to DATA.
  - DATA: on Tick: if bit_cnt==DATA_BITS-1, go to PARITY (PARITY_EN=1) or STOP; otherwise shift right, bit_cnt+1, TxD<=next bit.
    - Entering PARITY: TxD<=^data XOR PARITY_ODD.
    - Entering STOP: TxD<=1, stop_cnt<=0.
  - PARITY: on Tick: TxD<=1, stop_cnt<=0, go to STOP.
  - STOP: on Tick: if stop_cnt==STOP_BITS-1, the frame ends and TxDone=1 for that cycle:
    - if hold_full, load the new byte, TxD<=0, go to START (no idle gap);
    - otherwise TxD<=1, go to IDLE.
    Otherwise stop_cnt+1.
- Parity is computed over the latched byte, never the live TxData.
- Latency: the start bit begins at the first Tick edge strictly after the accept cycle. Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS Tick periods.
- TxData changing after accept has no effect.
- bit_cnt width = $clog2(DATA_BITS); stop_cnt is 1 bit; no wrap beyond its terminal values.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - parity mode constants (PAR_EVEN=0, PAR_ODD=1);
  - a parity function (reduction XOR with odd select), reused by the future receiver.
- No sub-module. The baud generator is instantiated beside this block at the parent level, and its Tick is wired to Tick here.

Test Plan:
1. Rst high 2 cycles with TxValid=1 -> TxD=1, TxReady=1, TxBusy=0, TxDone=0 throughout reset, and no accept is taken.
2. 8N1, Tick every 4 Clk, send 0x55 -> TxD = 0,1,0,1,0,1,0,1,0,1, each level held exactly 4 Clk; TxDone pulses once at the 10th Tick; TxBusy falls the same edge.
3. Send 0xA5, then 0x3C while 0xA5 is in DATA -> TxReady low until 0xA5's start Tick frees the hold; 0x3C's start bit immediately follows 0xA5's stop bit with no extra high period; two TxDone pulses 10 Ticks apart.
4. PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 Ticks.
5. STOP_BITS=2, send 0x00 -> TxD low for 9 Ticks, then high for 2 Ticks before TxDone; accept in the same cycle as an IDLE Tick -> start bit waits for the following Tick.
6. Assert Rst during data bit 3 with a byte held -> TxD=1 on the next cycle, TxBusy=0, TxReady=1, no TxDone, and the held byte is never transmitted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity modes and the parity helper.
// The parity helper is also meant for the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Narrower words must be zero-extended into the 9-bit argument.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Paced by an external bit-period Tick; a one-entry hold register allows gapless frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tick,
  input  logic                 TxValid,
  input  logic [DATA_BITS-1:0] TxData,
  output logic                 TxReady,
  output logic                 TxD,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int              CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic            PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_e            state,     state_nxt;
  logic [DATA_BITS-1:0] shifter,   shifter_nxt;
  logic [DATA_BITS-1:0] hold_data, hold_data_nxt;
  logic                 hold_full, hold_full_nxt;
  logic [CNT_W-1:0]     bit_cnt,   bit_cnt_nxt;
  logic                 stop_cnt,  stop_cnt_nxt;
  logic                 par_bit,   par_bit_nxt;
  logic                 tx_d,      tx_d_nxt;
  logic                 done,      done_nxt;
  logic                 accept;

  assign accept = TxValid & ~hold_full;

  always_ff @(posedge Clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (Rst) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_d      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      tx_d      <= tx_d_nxt;
      done      <= done_nxt;
    end
    // NOTE: pure datapath registers are left out of reset; hold_full and state gate every use of them.
    shifter   <= shifter_nxt;
    hold_data <= hold_data_nxt;
    par_bit   <= par_bit_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    shifter_nxt   = shifter;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    bit_cnt_nxt   = bit_cnt;
    stop_cnt_nxt  = stop_cnt;
    par_bit_nxt   = par_bit;
    tx_d_nxt      = tx_d;
    done_nxt      = 1'b0;

    if (accept) begin
      hold_full_nxt = 1'b1;
      hold_data_nxt = TxData;
    end

    if (Tick) begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            shifter_nxt   = hold_data;
            par_bit_nxt   = calc_parity(9'(hold_data), PAR_MODE);
            hold_full_nxt = 1'b0;
            tx_d_nxt      = 1'b0;
            state_nxt     = START;
          end
        end
        START: begin
          tx_d_nxt    = shifter[0];
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d_nxt  = par_bit;
              state_nxt = PARITY;
            end else begin
              tx_d_nxt     = 1'b1;
              stop_cnt_nxt = 1'b0;
              state_nxt    = STOP;
            end
          end else begin
            shifter_nxt = shifter >> 1;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            tx_d_nxt    = shifter[1];
          end
        end
        PARITY: begin
          tx_d_nxt     = 1'b1;
          stop_cnt_nxt = 1'b0;
          state_nxt    = STOP;
        end
        STOP: begin
          if (stop_cnt == LAST_STOP) begin
            done_nxt = 1'b1;
            // A held byte starts immediately so back-to-back frames have no idle gap.
            if (hold_full) begin
              shifter_nxt   = hold_data;
              par_bit_nxt   = calc_parity(9'(hold_data), PAR_MODE);
              hold_full_nxt = 1'b0;
              tx_d_nxt      = 1'b0;
              state_nxt     = START;
            end else begin
              tx_d_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
        default: begin
          tx_d_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign TxReady = ~hold_full;
  assign TxD     = tx_d;
  assign TxBusy  = (state != IDLE);
  assign TxDone  = done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, 8E1, 8O1 and 8N2 framing.
// Frames are hand-written bit vectors, bit 0 being the first bit on the line.
module tb_uart_tx;

  logic       Clk    = 1'b0;
  logic       Rst    = 1'b1;
  logic       Tick   = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic [3:0] valid  = 4'h0;
  logic [3:0] ready, txd, busy, done;

  int period = 4;
  int phase  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n1 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxValid(valid[0]), .TxData(TxData),
    .TxReady(ready[0]), .TxD(txd[0]), .TxBusy(busy[0]), .TxDone(done[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_e1 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxValid(valid[1]), .TxData(TxData),
    .TxReady(ready[1]), .TxD(txd[1]), .TxBusy(busy[1]), .TxDone(done[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_o1 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxValid(valid[2]), .TxData(TxData),
    .TxReady(ready[2]), .TxD(txd[2]), .TxBusy(busy[2]), .TxDone(done[2]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_n2 (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .TxValid(valid[3]), .TxData(TxData),
    .TxReady(ready[3]), .TxD(txd[3]), .TxBusy(busy[3]), .TxDone(done[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge Clk);
    #1;
    phase = (phase == period - 1) ? 0 : phase + 1;
    Tick  = (phase == 0);
  endtask

  task automatic send(input int idx, input logic [7:0] data);
    TxData     = data;
    valid[idx] = 1'b1;
    next_cycle();
    valid[idx] = 1'b0;
  endtask

  task automatic wait_start(input int idx, input string tag);
    for (int i = 0; i < 3 * period && !busy[idx]; i++) next_cycle();
    check({tag, "_start"}, busy[idx], 1);
  endtask

  // Cycle 0 is the first cycle after the start-bit edge.
  task automatic expect_seq(input int idx, input string tag, input logic [31:0] bits,
                            input int from, input int to);
    for (int i = from; i < to; i++) begin
      check($sformatf("%s_txd@%0d", tag, i), txd[idx], bits[i / period]);
      next_cycle();
    end
  endtask

  task automatic expect_end(input int idx, input string tag, input logic busy_exp,
                            input logic txd_exp);
    check({tag, "_done"}, done[idx], 1);
    check({tag, "_busy_end"}, busy[idx], busy_exp);
    check({tag, "_txd_end"}, txd[idx], txd_exp);
    next_cycle();
    check({tag, "_done_once"}, done[idx], 0);
  endtask

  initial begin
    // Reset held two cycles with every TxValid high.
    valid  = 4'hF;
    TxData = 8'hAA;
    repeat (2) begin
      next_cycle();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rst_txd%0d", k), txd[k], 1);
        check($sformatf("rst_ready%0d", k), ready[k], 1);
        check($sformatf("rst_busy%0d", k), busy[k], 0);
        check($sformatf("rst_done%0d", k), done[k], 0);
      end
    end
    Rst   = 1'b0;
    valid = 4'h0;
    next_cycle();
    for (int k = 0; k < 4; k++) check($sformatf("no_accept%0d", k), ready[k], 1);
    repeat (3 * period) next_cycle();
    for (int k = 0; k < 4; k++) check($sformatf("idle_busy%0d", k), busy[k], 0);

    // 8N1 0x55: alternating line, 10 Tick periods.
    send(0, 8'h55);
    check("n1_hold", ready[0], 0);
    wait_start(0, "n1");
    expect_seq(0, "n1", {1'b1, 8'h55, 1'b0}, 0, 40);
    expect_end(0, "n1", 1'b0, 1'b1);

    // Back-to-back 0xA5 then 0x3C, second byte accepted during data bits.
    send(0, 8'hA5);
    check("b2b_hold", ready[0], 0);
    wait_start(0, "b2b");
    check("b2b_freed", ready[0], 1);
    expect_seq(0, "b2b", {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 0, 12);
    TxData   = 8'h3C;
    valid[0] = 1'b1;
    expect_seq(0, "b2b", {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 12, 13);
    valid[0] = 1'b0;
    check("b2b_hold2", ready[0], 0);
    TxData = 8'hFF;
    expect_seq(0, "b2b", {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 13, 40);
    check("b2b_done1", done[0], 1);
    check("b2b_busy_mid", busy[0], 1);
    check("b2b_ready_mid", ready[0], 1);
    expect_seq(0, "b2b", {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 40, 80);
    expect_end(0, "b2b", 1'b0, 1'b1);

    // Parity on 0x07 (three ones): even -> 1, odd -> 0; 11 Tick periods.
    send(1, 8'h07);
    wait_start(1, "e1");
    expect_seq(1, "e1", {1'b1, 1'b1, 8'h07, 1'b0}, 0, 44);
    expect_end(1, "e1", 1'b0, 1'b1);
    send(2, 8'h07);
    wait_start(2, "o1");
    expect_seq(2, "o1", {1'b1, 1'b0, 8'h07, 1'b0}, 0, 44);
    expect_end(2, "o1", 1'b0, 1'b1);

    // Two stop bits; accept coincides with an IDLE Tick, so start waits one period.
    for (int i = 0; i < period && !Tick; i++) next_cycle();
    check("n2_tick_align", Tick, 1);
    send(3, 8'h00);
    check("n2_hold", ready[3], 0);
    check("n2_no_start", busy[3], 0);
    repeat (period - 1) next_cycle();
    check("n2_still_idle", busy[3], 0);
    check("n2_idle_txd", txd[3], 1);
    next_cycle();
    check("n2_start", busy[3], 1);
    expect_seq(3, "n2", {2'b11, 8'h00, 1'b0}, 0, 44);
    expect_end(3, "n2", 1'b0, 1'b1);

    // Reset during data bit 3 with a second byte held.
    send(0, 8'h55);
    wait_start(0, "ab");
    TxData   = 8'h0F;
    valid[0] = 1'b1;
    next_cycle();
    valid[0] = 1'b0;
    check("ab_held", ready[0], 0);
    repeat (16) next_cycle();
    check("ab_bit3", txd[0], 0);
    Rst = 1'b1;
    next_cycle();
    Rst = 1'b0;
    check("ab_txd", txd[0], 1);
    check("ab_busy", busy[0], 0);
    check("ab_ready", ready[0], 1);
    check("ab_done", done[0], 0);
    for (int i = 0; i < 60; i++) begin
      next_cycle();
      check($sformatf("ab_quiet_txd@%0d", i), txd[0], 1);
      check($sformatf("ab_quiet_busy@%0d", i), busy[0], 0);
      check($sformatf("ab_quiet_done@%0d", i), done[0], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
